// File: rtl/morse_tx_arbiter.sv
// Two-requester Morse LED arbiter with internal unit timebase and inter-message gap.
// Define MORSE_ARB_PRIORITY_EN for fixed priority (requester 0 wins) instead of round-robin.
module morse_tx_arbiter #(
  parameter int TICK_DIV  = 25_000_000,
  parameter int GAP_UNITS = 7,
  parameter int MAX_LEN   = 140
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iEnable,
  input  logic [1:0] iReq,
  input  logic [7:0] iLen0,
  input  logic [7:0] iLen1,
  input  logic       iBit0,
  input  logic       iBit1,
  output logic [7:0] oBitIdx,
  output logic [1:0] oGrant,
  output logic [1:0] oDone,
  output logic       oBusy,
  output logic       oLED
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [CW-1:0] UNIT_TC = CW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_TC  = GW'(GAP_UNITS - 1);
  localparam logic [8:0]    MAX9    =
    (MAX_LEN > 255) ? 9'd256 : 9'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [7:0]    len, len_d;
  logic [7:0]    idx_d;
  logic [1:0]    grant_d;
  logic [1:0]    done_d;
  logic          led_d;

  logic       sel;
  logic       win;
  logic [7:0] len_sel;
  logic       bit_sel;
  logic       len_bad;
  logic       unit_end;
  logic       last_bit;

  assign sel      = oGrant[1];
  assign len_sel  = sel ? iLen1 : iLen0;
  assign bit_sel  = sel ? iBit1 : iBit0;
  assign len_bad  = (len_sel == 8'd0) || ({1'b0, len_sel} > MAX9);
  assign unit_end = (cnt == UNIT_TC);
  assign last_bit = (oBitIdx == len - 8'd1);
  assign oBusy    = (state != IDLE);

`ifdef MORSE_ARB_PRIORITY_EN
  assign win = ~iReq[0];
`else
  logic last;

  // last-served requester gets lowest priority on a tie
  assign win = (&iReq) ? ~last : iReq[1];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      last <= 1'b1;
    end else if (|oGrant && grant_d == 2'b00) begin
      last <= oGrant[1];
    end
  end
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    len_d   = len;
    idx_d   = oBitIdx;
    grant_d = oGrant;
    done_d  = 2'b00;
    led_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (iEnable && |iReq) begin
          grant_d = win ? 2'b10 : 2'b01;
          state_d = LOAD;
        end
      end
      LOAD: begin
        len_d  = len_sel;
        idx_d  = 8'd0;
        cnt_d  = '0;
        gcnt_d = '0;
        if (len_bad) begin
          done_d  = oGrant;
          grant_d = 2'b00;
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!iReq[sel]) begin
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          led_d = bit_sel;
          if (unit_end) begin
            cnt_d = '0;
            if (last_bit) begin
              done_d  = oGrant;
              grant_d = 2'b00;
              state_d = GAP;
            end else begin
              idx_d = oBitIdx + 8'd1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      GAP: begin
        grant_d = 2'b00;
        if (unit_end) begin
          cnt_d = '0;
          if (gcnt == GAP_TC) begin
            gcnt_d  = '0;
            state_d = IDLE;
          end else begin
            gcnt_d = gcnt + GW'(1);
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      len     <= 8'd0;
      oBitIdx <= 8'd0;
      oGrant  <= 2'b00;
      oDone   <= 2'b00;
      oLED    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      gcnt    <= gcnt_d;
      len     <= len_d;
      oBitIdx <= idx_d;
      oGrant  <= grant_d;
      oDone   <= done_d;
      oLED    <= led_d;
    end
  end

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Randomized bench for morse_tx_arbiter against a message-timeline model.
// Honours MORSE_ARB_PRIORITY_EN in the arbitration model.
module tb_morse_tx_arbiter;

  localparam int TD = 4;
  localparam int GU = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] len0 = 8'd0;
  logic [7:0] len1 = 8'd0;
  logic       bit0, bit1;
  logic [7:0] idx;
  logic [1:0] grant, done;
  logic       busy, led;

  logic [255:0] data0 = '0;
  logic [255:0] data1 = '0;
  int   checks = 0;
  int   errors = 0;
  logic last_srv = 1'b1;

  morse_tx_arbiter #(
    .TICK_DIV (TD),
    .GAP_UNITS(GU),
    .MAX_LEN  (140)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .iEnable(en),
    .iReq   (req),
    .iLen0  (len0),
    .iLen1  (len1),
    .iBit0  (bit0),
    .iBit1  (bit1),
    .oBitIdx(idx),
    .oGrant (grant),
    .oDone  (done),
    .oBusy  (busy),
    .oLED   (led)
  );

  always #5 clk = ~clk;

  assign bit0 = data0[idx];
  assign bit1 = data1[idx];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic pick(input logic [1:0] r);
`ifdef MORSE_ARB_PRIORITY_EN
    return !r[0];
`else
    if (r == 2'b11) return !last_srv;
    return r[1];
`endif
  endfunction

  function automatic logic bitof(input logic w, input int k);
    return w ? data1[k] : data0[k];
  endfunction

  function automatic int rnd_len();
    int p;
    p = $urandom_range(0, 9);
    if (p == 0) return 0;
    if (p == 1) return $urandom_range(141, 255);
    return $urandom_range(1, 6);
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge of the
  // first idle cycle after the message (and gap, if any).
  task automatic run_msg(input logic [1:0] r, input int l0, input int l1,
                         input int ab);
    logic       w;
    int         l, end_t, ei;
    bit         ok;
    logic [1:0] g1h, eg, ed;
    logic       eb, el;
    en   = 1'b1;
    req  = r;
    len0 = 8'(l0);
    len1 = 8'(l1);
    w    = pick(r);
    l    = w ? l1 : l0;
    ok   = (l >= 1) && (l <= 140);
    g1h  = w ? 2'b10 : 2'b01;
    if (!ok) end_t = 1;
    else if (ab > 0) end_t = ab + 2 * TD;
    else end_t = TD * l + TD * GU + 1;
    for (int t = 0; t <= end_t; t++) begin
      @(negedge clk);
      eg = 2'b00;
      ed = 2'b00;
      eb = 1'b0;
      el = 1'b0;
      ei = -1;
      if (!ok) begin
        eg = (t == 0) ? g1h : 2'b00;
        ed = (t == 1) ? g1h : 2'b00;
        eb = (t == 0);
      end else if (ab > 0) begin
        eg = (t < ab) ? g1h : 2'b00;
        eb = (t < ab + TD * GU);
        if (t >= 2 && t < ab) el = bitof(w, (t - 2) / TD);
        if (t >= 1 && t < ab) ei = (t - 1) / TD;
      end else begin
        eg = (t <= TD * l) ? g1h : 2'b00;
        ed = (t == TD * l + 1) ? g1h : 2'b00;
        eb = (t < TD * l + TD * GU + 1);
        if (t >= 2 && t <= TD * l + 1) el = bitof(w, (t - 2) / TD);
        if (t >= 1 && t <= TD * l) ei = (t - 1) / TD;
      end
      check("grant", 32'(grant), 32'(eg));
      check("done", 32'(done), 32'(ed));
      check("busy", 32'(busy), 32'(eb));
      check("led", 32'(led), 32'(el));
      if (ei >= 0) check("bit_idx", 32'(idx), 32'(ei));
      if (ab > 0 && t == ab - 1) req[w] = 1'b0;
    end
    last_srv = w;
  endtask

  task automatic idle_gate();
    en  = 1'b0;
    req = 2'($urandom_range(1, 3));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gated_grant", 32'(grant), 32'd0);
      check("gated_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [1:0] r;
    int         l0, l1, l, ab;
    logic       w;

    repeat (2) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    rst_n = 1'b1;

    data0 = 256'b101;
    run_msg(2'b01, 3, 0, 0);

    data0 = 256'($urandom);
    data1 = 256'($urandom);
    run_msg(2'b11, 2, 2, 0);
    run_msg(2'b11, 2, 2, 0);

    run_msg(2'b01, 0, 0, 0);
    run_msg(2'b01, 150, 0, 0);

    data0 = 256'($urandom);
    run_msg(2'b01, 5, 0, 7);

    idle_gate();

    data0 = '1;
    en    = 1'b1;
    req   = 2'b01;
    len0  = 8'd5;
    for (int t = 0; t <= 4; t++) @(negedge clk);
    check("led_before_rst", 32'(led), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 32'(led), 32'd0);
    check("async_grant", 32'(grant), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_idx", 32'(idx), 32'd0);
    check("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    req      = 2'b00;
    last_srv = 1'b1;
    data1    = 256'($urandom);
    run_msg(2'b10, 3, 3, 0);

    for (int n = 0; n < 40; n++) begin
      data0 = {224'd0, 32'($urandom)};
      data1 = {224'd0, 32'($urandom)};
      r  = 2'($urandom_range(1, 3));
      l0 = rnd_len();
      l1 = rnd_len();
      w  = pick(r);
      l  = w ? l1 : l0;
      ab = 0;
      if (l >= 1 && l <= 140 && $urandom_range(0, 4) == 0)
        ab = $urandom_range(2, TD * l);
      run_msg(r, l0, l1, ab);
      if ($urandom_range(0, 4) == 0) idle_gate();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_tx_arbiter.md
# morse_tx_arbiter

Shares the single Morse output LED between two transmit requesters: the keypad TX path and a secondary source such as a beacon or replay generator. It generates the Morse unit timebase internally. It walks the granted requester's bit stream, one bit per unit, by driving a bit index. Each message is followed by an enforced inter-message gap. It sits between the TX bit-stream buffers and the board LED/output pin.

## Interface
- TICK_DIV, 25_000_000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2.
- GAP_UNITS, 7: units of forced LED-off after every completed or aborted message; must be ≥ 1.
- MAX_LEN, 140: maximum accepted message length in bits.
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iEnable  in  1  high = new grants allowed; low does not stop a transfer in progress.
- iReq  in  2  per-requester level request; hold high until granted and through transfer.
- iLen0, iLen1  in  8 each  message length in bits for requester 0 / 1.
- iBit0, iBit1  in  1 each  requester's buffer bit at oBitIdx (combinational lookup in requester).
- oBitIdx  out  8  index of bit currently being sent (LSB-first stream).
- oGrant  out  2  one-hot grant; zero when idle.
- oDone  out  2  one-cycle pulse on normal completion of a message, per requester.
- oBusy  out  1  high in any state other than IDLE.
- oLED  out  1  Morse output; 1 = on.

## Operation
- FSM states: IDLE, LOAD, SEND, GAP.
- **IDLE**
  - If iEnable and iReq ≠ 0, pick a winner and set oGrant, then go to LOAD.
  - Arbitration: round-robin. The last-granted requester has lowest priority. The pointer after reset favours requester 0.
- **LOAD**
  - Latch len = iLen of the winner. Clear oBitIdx and the unit counter.
  - len == 0 or len > MAX_LEN: pulse oDone[winner], clear oGrant, go to IDLE. No LED activity, no gap.
  - Otherwise go to SEND.
- **SEND**
  - Each cycle, oLED is registered from the selected iBit.
  - The unit counter counts 0..TICK_DIV−1.
  - At terminal count:
    - If oBitIdx == len−1: pulse oDone[g], go to GAP.
    - Else: oBitIdx += 1.
- **Abort**
  - If iReq[g] falls during SEND: go to GAP next cycle and force oLED to 0.
  - No oDone pulse on abort.
- **GAP**
  - oLED = 0 and oGrant = 0. Count GAP_UNITS × TICK_DIV cycles, then go to IDLE.
  - The round-robin pointer is updated to the just-served requester.
- iLen and the grant are frozen after LOAD; input changes during SEND are ignored, except the abort condition.
- Arithmetic:
  - Unit counter width is $clog2(TICK_DIV).
  - Gap counter width covers GAP_UNITS.
  - oBitIdx never exceeds len−1, so there is no wrap.
- A request arriving during SEND or GAP waits. It is never lost while held high.

## Timing
- Reset value of every output is 0: oLED, oGrant, oDone, oBusy, oBitIdx.
- Reset is asynchronous. Asserting iRST_N mid-message drives all outputs to 0 immediately. After release, the block is in IDLE with the pointer favouring requester 0.
- Request to grant: oGrant is registered 1 cycle after iReq is sampled high in IDLE. oBusy rises on the same edge.
- First LED bit: 2 cycles after grant. That is LOAD, then the first SEND cycle samples bit 0; oLED is valid on the following edge.
- Each bit occupies exactly TICK_DIV cycles on oLED, with 1-cycle lag behind oBitIdx.
- oDone pulses on the terminal-count edge of the last bit. oLED is 0 from that edge onward.
- From message end to the next grant: GAP_UNITS × TICK_DIV + 1 cycles minimum.

## Configuration
- MORSE_ARB_PRIORITY_EN defined: fixed priority. Requester 0 always wins when both iReq bits are high in IDLE, and the round-robin pointer is not implemented.
- Not defined: round-robin as described in Operation.

## Test plan
All scenarios use TICK_DIV=4, GAP_UNITS=2.
- **Single message:** iReq=01, iLen0=3, stream 1,0,1.
  - oGrant=01 after 1 cycle.
  - oLED: 4 high, 4 low, 4 high.
  - oDone[0] pulses once, then 8 cycles LED-off.
  - oBusy falls and oGrant=00 after the gap.
- **Simultaneous requests after reset:** iReq=11 held, len 2 each.
  - Requester 0 served first.
  - After its gap, oGrant=10 even though iReq[0] is still high.
- **Zero length:** iLen0=0 → oDone[0] pulse 2 cycles after request; oLED never high; back in IDLE with no gap. iLen0=150 behaves the same.
- **Abort:** drop iReq[0] during bit 1 of a 5-bit message.
  - oLED=0 on the next cycle; no oDone pulse.
  - Gap of 8 cycles, then IDLE.
- **Reset mid-SEND:** pull iRST_N low while oLED=1 → all outputs 0 without a clock edge. After release, iReq=10 is granted normally.
- **Priority build:** with MORSE_ARB_PRIORITY_EN and iReq=11 held, requester 0 is granted on every message and oGrant never equals 10.
